// File: rtl/pipe5_wb_port_arbiter.sv
// Register-file write-port arbiter: port 0 (pipeline writeback) has priority,
// ports >=1 share round-robin, and a starvation guard periodically preempts port 0.
module pipe5_wb_port_arbiter #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned STARVE_LIMIT = 8,
    parameter int unsigned WORD_W       = 32
) (
    input  logic                         CLK,
    input  logic                         nRST,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*5-1:0]         req_rd,
    input  logic [NUM_REQ*WORD_W-1:0]    req_data,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic                         rf_wen,
    output logic [4:0]                   rf_rd,
    output logic [WORD_W-1:0]            rf_wdata,
    output logic [$clog2(NUM_REQ)-1:0]   grant_idx,
    output logic                         pipe_stall
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

    typedef enum logic {
        ST_NORMAL = 1'b0,
        ST_STARVE = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]   starve_cnt_q, starve_cnt_d;

    logic               rf_wen_q, rf_wen_d;
    logic [4:0]         rf_rd_q, rf_rd_d;
    logic [WORD_W-1:0]  rf_wdata_q, rf_wdata_d;
    logic [IDX_W-1:0]   grant_idx_q, grant_idx_d;

    logic               rr_found;
    logic [IDX_W-1:0]   rr_win;
    logic               gnt_any;
    logic [IDX_W-1:0]   gnt_idx;
    logic               gnt_hi;
    logic               hi_valid;
    logic [NUM_REQ-1:0] grant;
    logic [4:0]         rd_sel;
    logic [WORD_W-1:0]  data_sel;

    assign hi_valid = |req_valid[NUM_REQ-1:1];

    // Round-robin scan over ports 1..NUM_REQ-1 starting at rr_ptr
    always_comb begin
        int unsigned      cand;
        logic [IDX_W-1:0] cand_idx;
        rr_found = 1'b0;
        rr_win   = '0;
        for (int unsigned off = 0; off < NUM_REQ - 1; off++) begin
            cand     = ((32'(rr_ptr_q) - 32'd1 + off) % (NUM_REQ - 1)) + 32'd1;
            cand_idx = IDX_W'(cand);
            if (!rr_found && req_valid[cand_idx]) begin
                rr_found = 1'b1;
                rr_win   = cand_idx;
            end
        end
    end

    // Grant selection, FSM next state, rr pointer and starvation counter update
    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        starve_cnt_d = starve_cnt_q;
        gnt_any      = 1'b0;
        gnt_idx      = '0;

        // No grants while reset is asserted: in-flight transfers are dropped
        if (nRST) begin
            case (state_q)
                ST_NORMAL: begin
                    if (req_valid[0]) begin
                        gnt_any = 1'b1;
                        gnt_idx = '0;
                    end else if (rr_found) begin
                        gnt_any = 1'b1;
                        gnt_idx = rr_win;
                    end
                end
                ST_STARVE: begin
                    if (rr_found) begin
                        gnt_any = 1'b1;
                        gnt_idx = rr_win;
                    end else if (req_valid[0]) begin
                        gnt_any = 1'b1;
                        gnt_idx = '0;
                    end
                end
                default: ;
            endcase
        end

        gnt_hi = gnt_any && (gnt_idx != '0);

        if (gnt_hi) begin
            starve_cnt_d = '0;
            rr_ptr_d     = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? IDX_W'(1) : gnt_idx + IDX_W'(1);
        end else if (hi_valid && (starve_cnt_q < CNT_W'(STARVE_LIMIT))) begin
            starve_cnt_d = starve_cnt_q + CNT_W'(1);
        end

        if (state_q == ST_STARVE) begin
            state_d      = ST_NORMAL;
            starve_cnt_d = '0;
        end else if (starve_cnt_d == CNT_W'(STARVE_LIMIT)) begin
            state_d = ST_STARVE;
        end
    end

    // One-hot ready vector from the selected grant
    always_comb begin
        grant = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_any && (gnt_idx == IDX_W'(i))) grant[i] = 1'b1;
        end
    end

    // Mux the granted requester's destination and data
    always_comb begin
        rd_sel   = '0;
        data_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_idx == IDX_W'(i)) begin
                rd_sel   = req_rd[5*i +: 5];
                data_sel = req_data[WORD_W*i +: WORD_W];
            end
        end
    end

    // Next values for the registered write port; rd==0 transfers write nothing
    always_comb begin
        rf_wen_d    = gnt_any && (rd_sel != 5'd0);
        rf_rd_d     = rf_wen_d ? rd_sel : 5'd0;
        rf_wdata_d  = rf_wen_d ? data_sel : '0;
        grant_idx_d = gnt_any ? gnt_idx : grant_idx_q;
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q      <= ST_NORMAL;
            rr_ptr_q     <= IDX_W'(1);
            starve_cnt_q <= '0;
            rf_wen_q     <= 1'b0;
            rf_rd_q      <= 5'd0;
            rf_wdata_q   <= '0;
            grant_idx_q  <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            starve_cnt_q <= starve_cnt_d;
            rf_wen_q     <= rf_wen_d;
            rf_rd_q      <= rf_rd_d;
            rf_wdata_q   <= rf_wdata_d;
            grant_idx_q  <= grant_idx_d;
        end
    end

    assign req_ready  = grant;
    assign pipe_stall = req_valid[0] & ~grant[0];
    assign rf_wen     = rf_wen_q;
    assign rf_rd      = rf_rd_q;
    assign rf_wdata   = rf_wdata_q;
    assign grant_idx  = grant_idx_q;

endmodule
